// File: rtl/iob_eth_mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO responder: FSM states, opcodes, field widths.
package iob_eth_mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ST,
        OP,
        PHYAD,
        REGAD,
        TA_RD,
        TA_WR
    } mdio_state_t;

    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;

    localparam int PHYAD_W   = 5;
    localparam int REGAD_W   = 5;
    localparam int DATA_W    = 16;
    localparam int BIT_CNT_W = 5;

    // Turnaround plus data spans R1..R18; the down-counter is loaded with 17 and ends at 0.
    localparam logic [BIT_CNT_W-1:0] CNT_OP_LOAD   = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] CNT_FIELD_LD  = BIT_CNT_W'(PHYAD_W - 1);
    localparam logic [BIT_CNT_W-1:0] CNT_TA_LOAD   = BIT_CNT_W'(DATA_W + 1);
    localparam logic [BIT_CNT_W-1:0] CNT_DATA_WIN  = BIT_CNT_W'(DATA_W);

endpackage

// File: rtl/iob_eth_mdio_sync_edge.sv
// Multi-flop synchronizer with a rising-edge detector on the synchronized level.
module iob_eth_mdio_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic cke_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (!rst_n_i) begin
                r_sync <= '0;
                r_prev <= 1'b0;
            end else begin
                r_sync <= {r_sync[STAGES-2:0], d_i};
                r_prev <= r_sync[STAGES-1];
            end
        end
    end

    assign level_o = r_sync[STAGES-1];
    assign rise_o  = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/iob_eth_mdio_responder.sv
// Clause-22 MDIO responder (PHY side) with a strobe-based register access port.
// Optional build macro IOB_ETH_MDIO_PREAMBLE_SUPPRESSION_EN: skip preamble after a completed frame.
//
// state | meaning
// IDLE  | counting preamble ones, waiting for the ST '0'
// ST    | expecting the ST '1'
// OP    | collecting the 2-bit opcode
// PHYAD | collecting the 5-bit PHY address
// REGAD | collecting the 5-bit register address, dispatch on last bit
// TA_RD | driving turnaround '0' then 16 read-data bits
// TA_WR | skipping turnaround, shifting in 16 write-data bits
module iob_eth_mdio_responder
    import iob_eth_mdio_pkg::*;
#(
    parameter logic [PHYAD_W-1:0] PHY_ADDR     = 5'd1,
    parameter int                 PREAMBLE_LEN = 32,
    parameter int                 SYNC_STAGES  = 2
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                rst_n_i,
    input  logic                mii_mdc_i,
    input  logic                mii_mdio_i,
    output logic                mii_mdio_o,
    output logic                mii_mdio_oe_o,
    output logic [REGAD_W-1:0]  reg_addr_o,
    output logic [DATA_W-1:0]   reg_wdata_o,
    output logic                reg_we_o,
    output logic                reg_re_o,
    input  logic [DATA_W-1:0]   reg_rdata_i,
    output logic                busy_o
);

    localparam int                PRE_W   = $clog2(PREAMBLE_LEN + 1);
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(PREAMBLE_LEN);
`ifdef IOB_ETH_MDIO_PREAMBLE_SUPPRESSION_EN
    localparam logic [PRE_W-1:0]  PRE_AFTER_OK = PRE_MAX;
`else
    localparam logic [PRE_W-1:0]  PRE_AFTER_OK = '0;
`endif

    logic w_mdc_rise;
    logic w_mdc_level_unused;
    logic w_mdio;
    logic w_mdio_rise_unused;

    iob_eth_mdio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mdc (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .rst_n_i (rst_n_i),
        .d_i     (mii_mdc_i),
        .level_o (w_mdc_level_unused),
        .rise_o  (w_mdc_rise)
    );

    iob_eth_mdio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mdio (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .rst_n_i (rst_n_i),
        .d_i     (mii_mdio_i),
        .level_o (w_mdio),
        .rise_o  (w_mdio_rise_unused)
    );

    mdio_state_t            r_state,    w_state_nxt;
    logic [PRE_W-1:0]       r_pre_cnt,  w_pre_nxt;
    logic [BIT_CNT_W-1:0]   r_bit_cnt,  w_bit_nxt;
    logic                   r_op_hi,    w_op_hi_nxt;
    logic                   r_is_rd,    w_is_rd_nxt;
    logic [PHYAD_W-1:0]     r_phyad,    w_phyad_nxt;
    logic [REGAD_W-1:0]     r_regad,    w_regad_nxt;
    logic [DATA_W-1:0]      r_shift,    w_shift_nxt;
    logic                   r_mdio_o,   w_mdio_o_nxt;
    logic                   r_mdio_oe,  w_mdio_oe_nxt;
    logic [REGAD_W-1:0]     r_reg_addr, w_reg_addr_nxt;
    logic [DATA_W-1:0]      r_reg_wdata, w_reg_wdata_nxt;
    logic                   r_reg_we,   w_reg_we_nxt;
    logic                   r_reg_re,   w_reg_re_nxt;

    logic                   w_bit_last;
    logic [REGAD_W-1:0]     w_regad_full;
    logic [DATA_W-1:0]      w_wdata_full;

    always_comb begin
        w_state_nxt     = r_state;
        w_pre_nxt       = r_pre_cnt;
        w_bit_nxt       = r_bit_cnt;
        w_op_hi_nxt     = r_op_hi;
        w_is_rd_nxt     = r_is_rd;
        w_phyad_nxt     = r_phyad;
        w_regad_nxt     = r_regad;
        w_shift_nxt     = r_shift;
        w_mdio_o_nxt    = r_mdio_o;
        w_mdio_oe_nxt   = r_mdio_oe;
        w_reg_addr_nxt  = r_reg_addr;
        w_reg_wdata_nxt = r_reg_wdata;
        w_reg_we_nxt    = 1'b0;
        w_reg_re_nxt    = 1'b0;
        w_bit_last      = (r_bit_cnt == '0);
        w_regad_full    = {r_regad[REGAD_W-2:0], w_mdio};
        w_wdata_full    = {r_shift[DATA_W-2:0], w_mdio};

        if (w_mdc_rise) begin
            unique case (r_state)
                IDLE: begin
                    if (w_mdio) begin
                        if (r_pre_cnt != PRE_MAX) begin
                            w_pre_nxt = r_pre_cnt + 1'b1;
                        end
                    end else if (r_pre_cnt == PRE_MAX) begin
                        w_state_nxt = ST;
                    end else begin
                        w_pre_nxt = '0;
                    end
                end
                ST: begin
                    if (w_mdio) begin
                        w_state_nxt = OP;
                        w_bit_nxt   = CNT_OP_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                        w_pre_nxt   = '0;
                    end
                end
                OP: begin
                    w_op_hi_nxt = w_mdio;
                    w_bit_nxt   = r_bit_cnt - 1'b1;
                    if (w_bit_last) begin
                        w_bit_nxt = CNT_FIELD_LD;
                        if ({r_op_hi, w_mdio} == OP_RD) begin
                            w_state_nxt = PHYAD;
                            w_is_rd_nxt = 1'b1;
                        end else if ({r_op_hi, w_mdio} == OP_WR) begin
                            w_state_nxt = PHYAD;
                            w_is_rd_nxt = 1'b0;
                        end else begin
                            w_state_nxt = IDLE;
                            w_pre_nxt   = '0;
                        end
                    end
                end
                PHYAD: begin
                    w_phyad_nxt = {r_phyad[PHYAD_W-2:0], w_mdio};
                    w_bit_nxt   = r_bit_cnt - 1'b1;
                    if (w_bit_last) begin
                        w_state_nxt = REGAD;
                        w_bit_nxt   = CNT_FIELD_LD;
                    end
                end
                REGAD: begin
                    w_regad_nxt = w_regad_full;
                    w_bit_nxt   = r_bit_cnt - 1'b1;
                    if (w_bit_last) begin
                        w_bit_nxt = CNT_TA_LOAD;
                        if (r_phyad != PHY_ADDR) begin
                            w_state_nxt = IDLE;
                            w_pre_nxt   = '0;
                        end else if (r_is_rd) begin
                            w_reg_addr_nxt = w_regad_full;
                            w_reg_re_nxt   = 1'b1;
                            w_state_nxt    = TA_RD;
                        end else begin
                            w_state_nxt = TA_WR;
                        end
                    end
                end
                TA_RD: begin
                    w_bit_nxt = r_bit_cnt - 1'b1;
                    // Read data arrived one clk after the strobe, long before R1.
                    if (r_bit_cnt == CNT_TA_LOAD) begin
                        w_mdio_oe_nxt = 1'b1;
                        w_mdio_o_nxt  = 1'b0;
                        w_shift_nxt   = reg_rdata_i;
                    end else if (w_bit_last) begin
                        w_mdio_oe_nxt = 1'b0;
                        w_mdio_o_nxt  = 1'b0;
                        w_state_nxt   = IDLE;
                        w_pre_nxt     = PRE_AFTER_OK;
                    end else begin
                        w_mdio_o_nxt = r_shift[DATA_W-1];
                        w_shift_nxt  = {r_shift[DATA_W-2:0], 1'b0};
                    end
                end
                TA_WR: begin
                    w_bit_nxt = r_bit_cnt - 1'b1;
                    if (r_bit_cnt < CNT_DATA_WIN) begin
                        w_shift_nxt = w_wdata_full;
                    end
                    if (w_bit_last) begin
                        w_reg_addr_nxt  = r_regad;
                        w_reg_wdata_nxt = w_wdata_full;
                        w_reg_we_nxt    = 1'b1;
                        w_state_nxt     = IDLE;
                        w_pre_nxt       = PRE_AFTER_OK;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_pre_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (!rst_n_i) begin
                r_state     <= IDLE;
                r_pre_cnt   <= '0;
                r_bit_cnt   <= '0;
                r_op_hi     <= 1'b0;
                r_is_rd     <= 1'b0;
                r_phyad     <= '0;
                r_regad     <= '0;
                r_shift     <= '0;
                r_mdio_o    <= 1'b0;
                r_mdio_oe   <= 1'b0;
                r_reg_addr  <= '0;
                r_reg_wdata <= '0;
                r_reg_we    <= 1'b0;
                r_reg_re    <= 1'b0;
            end else begin
                r_state     <= w_state_nxt;
                r_pre_cnt   <= w_pre_nxt;
                r_bit_cnt   <= w_bit_nxt;
                r_op_hi     <= w_op_hi_nxt;
                r_is_rd     <= w_is_rd_nxt;
                r_phyad     <= w_phyad_nxt;
                r_regad     <= w_regad_nxt;
                r_shift     <= w_shift_nxt;
                r_mdio_o    <= w_mdio_o_nxt;
                r_mdio_oe   <= w_mdio_oe_nxt;
                r_reg_addr  <= w_reg_addr_nxt;
                r_reg_wdata <= w_reg_wdata_nxt;
                r_reg_we    <= w_reg_we_nxt;
                r_reg_re    <= w_reg_re_nxt;
            end
        end
    end

    assign mii_mdio_o    = r_mdio_o;
    assign mii_mdio_oe_o = r_mdio_oe;
    assign reg_addr_o    = r_reg_addr;
    assign reg_wdata_o   = r_reg_wdata;
    assign reg_we_o      = r_reg_we;
    assign reg_re_o      = r_reg_re;
    assign busy_o        = (r_state != IDLE);

endmodule

// File: tb/tb_iob_eth_mdio_responder.sv
// Directed bench for iob_eth_mdio_responder: frames are bit-banged on MDC/MDIO from one initial block.
module tb_iob_eth_mdio_responder;

    localparam int HALF = 6;

    logic        clk_i = 1'b0;
    logic        cke_i;
    logic        rst_n_i;
    logic        mii_mdc_i;
    logic        mii_mdio_i;
    logic        mii_mdio_o;
    logic        mii_mdio_oe_o;
    logic [4:0]  reg_addr_o;
    logic [15:0] reg_wdata_o;
    logic        reg_we_o;
    logic        reg_re_o;
    logic [15:0] reg_rdata_i = 16'h0000;
    logic        busy_o;

    iob_eth_mdio_responder #(
        .PHY_ADDR     (5'd1),
        .PREAMBLE_LEN (32),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_i         (clk_i),
        .cke_i         (cke_i),
        .rst_n_i       (rst_n_i),
        .mii_mdc_i     (mii_mdc_i),
        .mii_mdio_i    (mii_mdio_i),
        .mii_mdio_o    (mii_mdio_o),
        .mii_mdio_oe_o (mii_mdio_oe_o),
        .reg_addr_o    (reg_addr_o),
        .reg_wdata_o   (reg_wdata_o),
        .reg_we_o      (reg_we_o),
        .reg_re_o      (reg_re_o),
        .reg_rdata_i   (reg_rdata_i),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    int          we_cnt = 0, re_cnt = 0, oe_cnt = 0, both_cnt = 0;
    logic [4:0]  we_addr = '0, re_addr = '0;
    logic [15:0] we_data = '0;

    // Register-file model: answers a read strobe with data for the strobed address.
    always @(negedge clk_i) begin
        if (reg_we_o === 1'b1) begin
            we_cnt++;
            we_addr = reg_addr_o;
            we_data = reg_wdata_o;
        end
        if (reg_re_o === 1'b1) begin
            re_cnt++;
            re_addr = reg_addr_o;
            reg_rdata_i = (reg_addr_o == 5'd2) ? 16'h1234 : 16'hDEAD;
        end
        if (mii_mdio_oe_o === 1'b1) oe_cnt++;
        if (reg_we_o === 1'b1 && reg_re_o === 1'b1) both_cnt++;
    end

    logic [17:0] cap_oe, cap_out;
    logic        busy_r0;
    int          hdr_re_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_bit(input logic b, output logic oe_s, output logic out_s, output logic busy_s);
        mii_mdio_i = b;
        mii_mdc_i  = 1'b0;
        tick(HALF);
        mii_mdc_i  = 1'b1;
        tick(HALF);
        oe_s   = mii_mdio_oe_o;
        out_s  = mii_mdio_o;
        busy_s = busy_o;
    endtask

    task automatic send_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                              input logic [4:0] rg, input logic [15:0] wd, input int ntail);
        logic [13:0] hdr;
        logic [17:0] tail;
        logic o, d, b;
        hdr  = {2'b01, op, phy, rg};
        tail = (op == 2'b01) ? {2'b10, wd} : 18'h3FFFF;
        cap_oe  = '0;
        cap_out = '0;
        for (int i = 0; i < pre; i++) send_bit(1'b1, o, d, b);
        for (int i = 13; i >= 0; i--) send_bit(hdr[i], o, d, b);
        busy_r0    = b;
        hdr_re_cnt = re_cnt;
        for (int i = 0; i < ntail; i++) begin
            send_bit(tail[17-i], o, d, b);
            cap_oe[i]  = o;
            cap_out[i] = d;
        end
    endtask

    initial begin
        int we0, re0, oe0;
        logic [15:0] rd_word;
        logic o, d, b;

        cke_i      = 1'b1;
        rst_n_i    = 1'b0;
        mii_mdc_i  = 1'b0;
        mii_mdio_i = 1'b1;
        tick(3);
        check("rst_oe",    32'(mii_mdio_oe_o), 32'h0);
        check("rst_mdio",  32'(mii_mdio_o),    32'h0);
        check("rst_addr",  32'(reg_addr_o),    32'h0);
        check("rst_wdata", 32'(reg_wdata_o),   32'h0);
        check("rst_strb",  32'({reg_we_o, reg_re_o}), 32'h0);
        check("rst_busy",  32'(busy_o),        32'h0);
        rst_n_i = 1'b1;
        tick(2);

        // Write PHY 1, reg 4, 0xBEEF
        we0 = we_cnt; oe0 = oe_cnt;
        send_frame(32, 2'b01, 5'd1, 5'd4, 16'hBEEF, 18);
        tick(2);
        check("wr_we_pulses", 32'(we_cnt - we0), 32'd1);
        check("wr_addr",      32'(we_addr),      32'd4);
        check("wr_data",      32'(we_data),      32'hBEEF);
        check("wr_oe_never",  32'(oe_cnt - oe0), 32'd0);
        check("wr_busy_end",  32'(busy_o),       32'h0);

        // Read PHY 1, reg 2 -> 0x1234
        we0 = we_cnt; re0 = re_cnt;
        send_frame(32, 2'b10, 5'd1, 5'd2, 16'h0000, 18);
        check("rd_re_at_r0",  32'(hdr_re_cnt - re0), 32'd1);
        check("rd_re_pulses", 32'(re_cnt - re0),     32'd1);
        check("rd_re_addr",   32'(re_addr),          32'd2);
        check("rd_no_we",     32'(we_cnt - we0),     32'd0);
        check("rd_oe_window", 32'(cap_oe),           32'h1FFFF);
        check("rd_ta_bit",    32'(cap_out[0]),       32'h0);
        for (int k = 0; k < 16; k++) rd_word[15-k] = cap_out[k+1];
        check("rd_data",      32'(rd_word),          32'h1234);

        // Read to PHY 3: not ours
        we0 = we_cnt; re0 = re_cnt; oe0 = oe_cnt;
        send_frame(32, 2'b10, 5'd3, 5'd2, 16'h0000, 18);
        check("mis_busy_r0",  32'(busy_r0),          32'h0);
        check("mis_strobes",  32'((we_cnt - we0) + (re_cnt - re0)), 32'd0);
        check("mis_oe",       32'(oe_cnt - oe0),     32'd0);

        // Short preamble (31) after a clearing zero: ignored; full preamble accepted
        send_bit(1'b0, o, d, b);
        we0 = we_cnt;
        send_frame(31, 2'b01, 5'd1, 5'd4, 16'hBEEF, 18);
        check("pre31_ignored", 32'(we_cnt - we0), 32'd0);
        we0 = we_cnt;
        send_frame(32, 2'b01, 5'd1, 5'd5, 16'hC3A5, 18);
        check("pre32_we",   32'(we_cnt - we0), 32'd1);
        check("pre32_addr", 32'(we_addr),      32'd5);
        check("pre32_data", 32'(we_data),      32'hC3A5);

        // Reset in the middle of read data; reset ignored while cke_i is low
        send_frame(32, 2'b10, 5'd1, 5'd2, 16'h0000, 7);
        check("mid_oe_on", 32'(cap_oe[6]), 32'h1);
        cke_i   = 1'b0;
        rst_n_i = 1'b0;
        tick(2);
        check("frz_oe",   32'(mii_mdio_oe_o), 32'h1);
        check("frz_busy", 32'(busy_o),        32'h1);
        cke_i = 1'b1;
        tick(1);
        check("mid_rst_oe",   32'(mii_mdio_oe_o), 32'h0);
        check("mid_rst_busy", 32'(busy_o),        32'h0);
        check("mid_rst_addr", 32'(reg_addr_o),    32'h0);
        rst_n_i = 1'b1;
        we0 = we_cnt;
        send_frame(32, 2'b01, 5'd1, 5'd7, 16'h5A5A, 18);
        check("post_rst_we",   32'(we_cnt - we0), 32'd1);
        check("post_rst_addr", 32'(we_addr),      32'd7);
        check("post_rst_data", 32'(we_data),      32'h5A5A);

        // Back-to-back write with a single idle '1'
        we0 = we_cnt;
        send_frame(1, 2'b01, 5'd1, 5'd9, 16'h0F0F, 18);
`ifdef IOB_ETH_MDIO_PREAMBLE_SUPPRESSION_EN
        check("gap_we",   32'(we_cnt - we0), 32'd1);
        check("gap_data", 32'(we_data),      32'h0F0F);
`else
        check("gap_we",   32'(we_cnt - we0), 32'd0);
`endif

        check("never_both", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
